// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared definitions for the debounce bank:
//   - db_state_e  : per-channel FSM state encoding
//   - DEF_*       : default parameter values used by debounce_ch / debounce_bank
//   - state_level : debounced level implied by an FSM state
// Optional feature macro: DEBOUNCE_REPEAT_EN (auto-repeat, used by the modules)
// -----------------------------------------------------------------------------
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    PRESS_PEND = 2'b01,
    HELD       = 2'b10,
    REL_PEND   = 2'b11
  } db_state_e;

  localparam int DEF_NUM_CH        = 4;
  localparam int DEF_CNT_W         = 16;
  localparam int DEF_STABLE_CYCLES = 65535;
  localparam int DEF_RPT_W         = 24;
  localparam int DEF_REPEAT_DELAY  = 8000000;
  localparam int DEF_REPEAT_PERIOD = 2000000;

  // The pending states still report the old stable level.
  function automatic logic state_level(input db_state_e s);
    logic lvl;
    case (s)
      HELD, REL_PEND: lvl = 1'b1;
      default:        lvl = 1'b0;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// -----------------------------------------------------------------------------
// debounce_ch
// One debounced button channel: 2-flop synchronizer, 4-state debounce FSM with
// saturating stability counter, registered level/press/release outputs and,
// when DEBOUNCE_REPEAT_EN is defined, an auto-repeat pulse generator.
// Ports:
//   clk    in   system clock (rising edge)
//   rst_n  in   asynchronous active-low reset
//   button in   raw asynchronous button level, 1 = pressed
//   level  out  debounced level
//   press  out  one-cycle pulse on debounced 0->1
//   rel    out  one-cycle pulse on debounced 1->0
//   rpt    out  one-cycle auto-repeat pulse while held (0 without the macro)
// -----------------------------------------------------------------------------
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int CNT_W         = DEF_CNT_W,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
`ifdef DEBOUNCE_REPEAT_EN
  ,
  parameter int RPT_W         = DEF_RPT_W,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic level,
  output logic press,
  output logic rel,
  output logic rpt
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(STABLE_CYCLES);
  // A one-cycle stability window needs no pending dwell at all.
  localparam bit DIRECT_FLIP = (STABLE_CYCLES == 1);

  logic             sync1_r;
  logic             sync2_r;
  db_state_e        state_r;
  db_state_e        state_nxt;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt;
  logic             level_r;
  logic             press_r;
  logic             press_nxt;
  logic             rel_r;
  logic             rel_nxt;

  // Two-flop synchronizer for the raw button level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= button;
      sync2_r <= sync1_r;
    end
  end

  // Debounce FSM next-state, counter and pulse decode.
  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = cnt_r;
    press_nxt = 1'b0;
    rel_nxt   = 1'b0;
    case (state_r)
      IDLE: begin
        if (sync2_r) begin
          if (DIRECT_FLIP) begin
            state_nxt = HELD;
            press_nxt = 1'b1;
            cnt_nxt   = CNT_ZERO;
          end else begin
            state_nxt = PRESS_PEND;
            cnt_nxt   = CNT_ONE;
          end
        end else begin
          cnt_nxt = CNT_ZERO;
        end
      end
      PRESS_PEND: begin
        if (!sync2_r) begin
          state_nxt = IDLE;
          cnt_nxt   = CNT_ZERO;
        end else if (cnt_r == CNT_TERM) begin
          state_nxt = HELD;
          press_nxt = 1'b1;
          cnt_nxt   = CNT_ZERO;
        end else begin
          cnt_nxt = cnt_r + CNT_ONE;
        end
      end
      HELD: begin
        if (!sync2_r) begin
          if (DIRECT_FLIP) begin
            state_nxt = IDLE;
            rel_nxt   = 1'b1;
            cnt_nxt   = CNT_ZERO;
          end else begin
            state_nxt = REL_PEND;
            cnt_nxt   = CNT_ONE;
          end
        end else begin
          cnt_nxt = CNT_ZERO;
        end
      end
      REL_PEND: begin
        if (sync2_r) begin
          state_nxt = HELD;
          cnt_nxt   = CNT_ZERO;
        end else if (cnt_r == CNT_TERM) begin
          state_nxt = IDLE;
          rel_nxt   = 1'b1;
          cnt_nxt   = CNT_ZERO;
        end else begin
          cnt_nxt = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  // FSM state, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      level_r <= 1'b0;
      press_r <= 1'b0;
      rel_r   <= 1'b0;
    end else begin
      state_r <= state_nxt;
      cnt_r   <= cnt_nxt;
      level_r <= state_level(state_nxt);
      press_r <= press_nxt;
      rel_r   <= rel_nxt;
    end
  end

  assign level = level_r;
  assign press = press_r;
  assign rel   = rel_r;

`ifdef DEBOUNCE_REPEAT_EN
  localparam logic [RPT_W-1:0] RPT_ZERO  = {RPT_W{1'b0}};
  localparam logic [RPT_W-1:0] RPT_ONE   = RPT_W'(1);
  localparam logic [RPT_W-1:0] DELAY_C   = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] PERIOD_C  = RPT_W'(REPEAT_PERIOD);

  logic [RPT_W-1:0] rpt_cnt_r;
  logic [RPT_W-1:0] rpt_cnt_nxt;
  logic [RPT_W-1:0] rpt_inc_s;
  logic             armed_r;
  logic             armed_nxt;
  logic             rpt_r;
  logic             rpt_nxt;

  // Repeat counter: runs only on cycles that stay in HELD. The first target is
  // the initial delay; once it fires (armed) the period is used. Anything that
  // leaves HELD, including the start of a release, clears it.
  always_comb begin
    rpt_cnt_nxt = rpt_cnt_r;
    armed_nxt   = armed_r;
    rpt_nxt     = 1'b0;
    rpt_inc_s   = rpt_cnt_r + RPT_ONE;
    if ((state_r == HELD) && (state_nxt == HELD)) begin
      if ((!armed_r && (rpt_inc_s == DELAY_C)) || (armed_r && (rpt_inc_s == PERIOD_C))) begin
        rpt_nxt     = 1'b1;
        rpt_cnt_nxt = RPT_ZERO;
        armed_nxt   = 1'b1;
      end else begin
        rpt_cnt_nxt = rpt_inc_s;
      end
    end else begin
      rpt_cnt_nxt = RPT_ZERO;
      armed_nxt   = 1'b0;
    end
  end

  // Repeat counter and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt_r <= RPT_ZERO;
      armed_r   <= 1'b0;
      rpt_r     <= 1'b0;
    end else begin
      rpt_cnt_r <= rpt_cnt_nxt;
      armed_r   <= armed_nxt;
      rpt_r     <= rpt_nxt;
    end
  end

  assign rpt = rpt_r;
`else
  assign rpt = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// -----------------------------------------------------------------------------
// debounce_bank
// Bank of NUM_CH fully independent debounced button channels.
// Optional feature macro: DEBOUNCE_REPEAT_EN enables per-channel auto-repeat;
// without it repeat_o is tied low and no repeat logic exists.
// Ports:
//   clk        in   system clock (rising edge)
//   rst_n      in   asynchronous active-low reset
//   button     in   [NUM_CH] raw button levels, 1 = pressed
//   level_o    out  [NUM_CH] debounced levels
//   press_o    out  [NUM_CH] one-cycle pulse on debounced 0->1
//   release_o  out  [NUM_CH] one-cycle pulse on debounced 1->0
//   repeat_o   out  [NUM_CH] one-cycle auto-repeat pulse while held
// -----------------------------------------------------------------------------
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int NUM_CH        = DEF_NUM_CH,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int RPT_W         = DEF_RPT_W,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] button,
  output logic [NUM_CH-1:0] level_o,
  output logic [NUM_CH-1:0] press_o,
  output logic [NUM_CH-1:0] release_o,
  output logic [NUM_CH-1:0] repeat_o
);

  // Legal parameter ranges; an illegal set shows up as the g_cfg_out_of_range
  // scope in the elaborated hierarchy.
  localparam bit CFG_OK =
      (NUM_CH >= 1) && (NUM_CH <= 32) &&
      (CNT_W >= 1) && (CNT_W <= 32) &&
      (STABLE_CYCLES >= 1) &&
      (longint'(STABLE_CYCLES) <= ((longint'(1) << CNT_W) - longint'(1))) &&
      (RPT_W >= 1) && (RPT_W <= 32) &&
      (REPEAT_DELAY >= 1) &&
      (longint'(REPEAT_DELAY) <= ((longint'(1) << RPT_W) - longint'(1))) &&
      (REPEAT_PERIOD >= 1) &&
      (longint'(REPEAT_PERIOD) <= ((longint'(1) << RPT_W) - longint'(1)));

  if (!CFG_OK) begin : g_cfg_out_of_range
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_ch #(
      .CNT_W         (CNT_W),
      .STABLE_CYCLES (STABLE_CYCLES)
`ifdef DEBOUNCE_REPEAT_EN
      ,
      .RPT_W         (RPT_W),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .button (button[i]),
      .level  (level_o[i]),
      .press  (press_o[i]),
      .rel    (release_o[i]),
      .rpt    (repeat_o[i])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
// -----------------------------------------------------------------------------
// tb_debounce_bank
// Directed bench for debounce_bank with NUM_CH=2, STABLE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=3. Inputs change 1 ns after a rising edge;
// outputs are sampled 1 ns after a rising edge. Edge E0 is the first rising
// edge that samples a new button value; a clean change appears at E6.
// -----------------------------------------------------------------------------
module tb_debounce_bank;

  localparam int NUM_CH = 2;

  logic              clk;
  logic              rst_n;
  logic [NUM_CH-1:0] button;
  logic [NUM_CH-1:0] level_o;
  logic [NUM_CH-1:0] press_o;
  logic [NUM_CH-1:0] release_o;
  logic [NUM_CH-1:0] repeat_o;

  int n_assert;
  int n_fail;

  debounce_bank #(
    .NUM_CH        (NUM_CH),
    .CNT_W         (4),
    .STABLE_CYCLES (4),
    .RPT_W         (8),
    .REPEAT_DELAY  (10),
    .REPEAT_PERIOD (3)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .button    (button),
    .level_o   (level_o),
    .press_o   (press_o),
    .release_o (release_o),
    .repeat_o  (repeat_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [NUM_CH-1:0] obs, input logic [NUM_CH-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Without auto-repeat the output must stay low whatever is expected with it.
  function automatic logic [NUM_CH-1:0] rpt_exp(input logic [NUM_CH-1:0] v);
`ifdef DEBOUNCE_REPEAT_EN
    return v;
`else
    return (v & 2'b00);
`endif
  endfunction

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    button   = 2'b00;

    // Reset state
    tick(); tick(); tick();
    chk("rst_level",   level_o,   2'b00);
    chk("rst_press",   press_o,   2'b00);
    chk("rst_release", release_o, 2'b00);
    chk("rst_repeat",  repeat_o,  2'b00);
    rst_n = 1'b1;
    tick(); tick();

    // Clean press on ch0: level/press at E6 only, ch1 quiet
    button = 2'b01;
    for (int k = 0; k <= 6; k++) begin
      tick();
      chk($sformatf("press0_level_E%0d", k), level_o, (k == 6) ? 2'b01 : 2'b00);
      chk($sformatf("press0_pulse_E%0d", k), press_o, (k == 6) ? 2'b01 : 2'b00);
      chk($sformatf("press0_rel_E%0d", k), release_o, 2'b00);
    end
    tick();
    chk("press0_pulse_E7", press_o, 2'b00);
    chk("press0_level_E7", level_o, 2'b01);

    // Clean release on ch0: release pulse at R6 only
    button = 2'b00;
    for (int k = 0; k <= 6; k++) begin
      tick();
      chk($sformatf("rel0_level_E%0d", k), level_o, (k == 6) ? 2'b00 : 2'b01);
      chk($sformatf("rel0_pulse_E%0d", k), release_o, (k == 6) ? 2'b01 : 2'b00);
      chk($sformatf("rel0_press_E%0d", k), press_o, 2'b00);
      chk($sformatf("rel0_rpt_E%0d", k), repeat_o, 2'b00);
    end
    tick();
    chk("rel0_pulse_E7", release_o, 2'b00);
    tick(); tick();

    // Glitch: ch0 high for 3 sampled edges then low -> nothing happens
    button = 2'b01;
    tick(); tick(); tick();
    button = 2'b00;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("glitch_press_%0d", k), press_o, 2'b00);
      chk($sformatf("glitch_level_%0d", k), level_o, 2'b00);
    end

    // Both channels pressed on the same edge (also shows ch0 counts from zero)
    button = 2'b11;
    for (int k = 0; k <= 6; k++) begin
      tick();
      chk($sformatf("both_press_E%0d", k), press_o, (k == 6) ? 2'b11 : 2'b00);
      chk($sformatf("both_level_E%0d", k), level_o, (k == 6) ? 2'b11 : 2'b00);
    end
    button = 2'b00;
    for (int k = 0; k <= 6; k++) begin
      tick();
      chk($sformatf("both_rel_E%0d", k), release_o, (k == 6) ? 2'b11 : 2'b00);
    end
    tick(); tick();

    // Reset during PRESS_PEND with ch1 already held
    button = 2'b10;
    for (int k = 0; k < 8; k++) tick();
    chk("pre_rst_level", level_o, 2'b10);
    button = 2'b11;
    tick(); tick(); tick(); tick();
    chk("pend_level", level_o, 2'b10);
    rst_n = 1'b0;
    #1;
    chk("async_rst_level",   level_o,   2'b00);
    chk("async_rst_press",   press_o,   2'b00);
    chk("async_rst_release", release_o, 2'b00);
    tick(); tick();
    chk("in_rst_level", level_o, 2'b00);
    chk("in_rst_press", press_o, 2'b00);
    rst_n = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      tick();
      chk($sformatf("post_rst_press_E%0d", k), press_o, (k == 6) ? 2'b11 : 2'b00);
      chk($sformatf("post_rst_level_E%0d", k), level_o, (k == 6) ? 2'b11 : 2'b00);
      chk($sformatf("post_rst_rel_E%0d", k), release_o, 2'b00);
    end

    // Held: repeats at press+10, +13, +16
    for (int m = 1; m <= 16; m++) begin
      tick();
      chk($sformatf("hold_rpt_P+%0d", m), repeat_o,
          rpt_exp((m == 10 || m == 13 || m == 16) ? 2'b11 : 2'b00));
      chk($sformatf("hold_press_P+%0d", m), press_o, 2'b00);
    end
    // Release: no repeats once release starts, release pulse at R6
    button = 2'b00;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("final_rpt_E%0d", k), repeat_o, 2'b00);
      chk($sformatf("final_rel_E%0d", k), release_o, (k == 6) ? 2'b11 : 2'b00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
